csa_pipe_addsub: RTL and testbench

- Parametrised, pipelined carry-skip adder/subtractor. Next generation of the team's 32-bit combinational carry-skip adder.
- Adds configurable width, skip-group size and pipeline depth, plus an add/sub mode and status flags (carry, signed overflow, zero).
- Valid/ready handshakes on both sides, so it drops into streaming datapaths: ALU back-ends and accumulators.

---
 rtl/csa_pkg.sv | 30 +++
 rtl/csa_skip_group.sv | 39 +++
 rtl/csa_pipe_addsub.sv | 180 ++++++++++++++++++
 tb/tb_csa_pipe_addsub.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Sizing helpers and parameter legality check shared by the carry-skip adder files.
package csa_pkg;

    // Number of skip groups across the full operand width.
    function automatic int unsigned csa_ngrp(input int unsigned width, input int unsigned group);
        return (group == 32'd0) ? 32'd0 : width / group;
    endfunction

    // Number of result bits owned by each pipeline stage.
    function automatic int unsigned csa_slice(input int unsigned width, input int unsigned stages);
        return (stages == 32'd0) ? 32'd0 : width / stages;
    endfunction

    // True when WIDTH splits evenly into groups and the groups split evenly across stages.
    function automatic bit csa_params_ok(input int unsigned width,
                                         input int unsigned group,
                                         input int unsigned stages);
        if (width == 32'd0 || group == 32'd0 || stages == 32'd0) begin
            return 1'b0;
        end
        if ((width % group) != 32'd0) begin
            return 1'b0;
        end
        if (((width / group) % stages) != 32'd0) begin
            return 1'b0;
        end
        return 1'b1;
    endfunction

endpackage

// File: rtl/csa_skip_group.sv
// One carry-skip group: rippled sum bits plus a skip mux on the group carry-out.
module csa_skip_group
    import csa_pkg::*;
#(
    parameter int unsigned GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] s,
    output logic             cout,
    output logic             c_msb_in
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic             c_ripple;

    assign p = a ^ b;
    assign g = a & b;

    // Ripple through the group; the last loop pass leaves the carry entering the top bit.
    always_comb begin
        logic c;
        c        = cin;
        s        = '0;
        c_msb_in = cin;
        for (int i = 0; i < int'(GROUP); i++) begin
            s[i]     = p[i] ^ c;
            c_msb_in = c;
            c        = g[i] | (p[i] & c);
        end
        c_ripple = c;
    end

    // A fully propagating group passes its carry-in straight through.
    assign cout = (&p) ? cin : c_ripple;

endmodule

// File: rtl/csa_pipe_addsub.sv
// Pipelined carry-skip adder/subtractor with valid/ready on both sides.
// Stage k resolves bits [k*SLICE +: SLICE]; operands skew forward, finished slices deskew.
module csa_pipe_addsub
    import csa_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned GROUP  = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int unsigned NGRP  = csa_ngrp(WIDTH, GROUP);
    localparam int unsigned SLICE = csa_slice(WIDTH, STAGES);
    localparam int unsigned GPS   = NGRP / STAGES;

    // Refuse to elaborate shapes that do not tile evenly.
    if (!csa_params_ok(WIDTH, GROUP, STAGES)) begin : g_param_check
        $error("csa_pipe_addsub: illegal WIDTH/GROUP/STAGES combination");
    end

    logic [WIDTH-1:0]  bx_in;
    logic              c0;
    logic [STAGES-1:0] v;
    logic [STAGES-1:0] adv;

    // Subtraction is a + ~b + 1; cin only matters when adding.
    assign bx_in = sub ? ~b : b;
    assign c0    = sub | cin;

    // A stage may load when some stage at or after it has room, or the sink drains.
    for (genvar k = 0; k < STAGES; k++) begin : g_adv
        assign adv[k] = out_ready | ~(&v[STAGES-1:k]);
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned REM  = WIDTH - (k + 1) * SLICE;
        localparam int unsigned DONE = (k + 1) * SLICE;

        logic [SLICE-1:0] op_a;
        logic [SLICE-1:0] op_b;
        logic [SLICE-1:0] s_slice;
        logic [GPS-1:0]   gmsb;
        logic [DONE-1:0]  sum_nxt;
        logic [DONE-1:0]  sum_r;
        logic             c_in;
        logic             src_v;
        logic             load;
        logic             slice_co;
        logic             v_r;
        logic             c_r;
        logic             unused_msb;

        // Select operands, carry and valid from the ports or the previous stage.
        if (k == 0) begin : g_src
            assign op_a    = a[SLICE-1:0];
            assign op_b    = bx_in[SLICE-1:0];
            assign c_in    = c0;
            assign src_v   = in_valid;
            assign sum_nxt = s_slice;
        end else begin : g_src
            assign op_a    = g_stage[k-1].g_skew.a_r[SLICE-1:0];
            assign op_b    = g_stage[k-1].g_skew.bx_r[SLICE-1:0];
            assign c_in    = g_stage[k-1].c_r;
            assign src_v   = g_stage[k-1].v_r;
            assign sum_nxt = {s_slice, g_stage[k-1].sum_r};
        end

        // Chain this stage's skip groups; each group's carry feeds the next.
        for (genvar j = 0; j < GPS; j++) begin : g_grp
            logic ci;
            logic co;
            if (j == 0) begin : g_ci
                assign ci = c_in;
            end else begin : g_ci
                assign ci = g_grp[j-1].co;
            end
            csa_skip_group #(
                .GROUP    (GROUP)
            ) u_grp (
                .a        (op_a[j*GROUP +: GROUP]),
                .b        (op_b[j*GROUP +: GROUP]),
                .cin      (ci),
                .s        (s_slice[j*GROUP +: GROUP]),
                .cout     (co),
                .c_msb_in (gmsb[j])
            );
        end

        assign slice_co   = g_grp[GPS-1].co;
        assign load       = adv[k] & src_v;
        assign v[k]       = v_r;
        // Only the top group's MSB carry-in is meaningful, and only in the last stage.
        assign unused_msb = ^gmsb;

        // Stage occupancy: refill from upstream whenever this stage advances.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                v_r <= 1'b0;
            end else if (adv[k]) begin
                v_r <= src_v;
            end
        end

        // Capture this slice's sum and carry alongside the lower slices already resolved.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                c_r   <= 1'b0;
                sum_r <= '0;
            end else if (load) begin
                c_r   <= slice_co;
                sum_r <= sum_nxt;
            end
        end

        // Carry the not-yet-processed upper operand bits to the next stage.
        if (REM > 0) begin : g_skew
            logic [REM-1:0] a_r;
            logic [REM-1:0] bx_r;
            logic [REM-1:0] a_nxt;
            logic [REM-1:0] bx_nxt;

            if (k == 0) begin : g_up
                assign a_nxt  = a[WIDTH-1:SLICE];
                assign bx_nxt = bx_in[WIDTH-1:SLICE];
            end else begin : g_up
                assign a_nxt  = g_stage[k-1].g_skew.a_r[REM+SLICE-1:SLICE];
                assign bx_nxt = g_stage[k-1].g_skew.bx_r[REM+SLICE-1:SLICE];
            end

            // Operand skew registers.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    a_r  <= '0;
                    bx_r <= '0;
                end else if (load) begin
                    a_r  <= a_nxt;
                    bx_r <= bx_nxt;
                end
            end
        end

        // Status flags from the complete result, registered with it in the last stage.
        if (k == STAGES - 1) begin : g_flags
            logic ovf_r;
            logic zero_r;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    ovf_r  <= 1'b0;
                    zero_r <= 1'b0;
                end else if (load) begin
                    ovf_r  <= gmsb[GPS-1] ^ slice_co;
                    zero_r <= ~|sum_nxt;
                end
            end
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = v[STAGES-1];
    assign sum       = g_stage[STAGES-1].sum_r;
    assign cout      = g_stage[STAGES-1].c_r;
    assign ovf       = g_stage[STAGES-1].g_flags.ovf_r;
    assign zero      = g_stage[STAGES-1].g_flags.zero_r;

endmodule

// File: tb/tb_csa_pipe_addsub.sv
// Self-checking bench for csa_pipe_addsub: arithmetic reference model plus directed corner cases.
module tb_csa_pipe_addsub;

    localparam int unsigned WIDTH  = 32;
    localparam int unsigned GROUP  = 4;
    localparam int unsigned STAGES = 2;

    typedef struct packed {
        logic             zero;
        logic             ovf;
        logic             cout;
        logic [WIDTH-1:0] sum;
    } res_t;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;
    logic             zero;

    int   total = 0;
    int   bad   = 0;
    int   n_in  = 0;
    int   n_out = 0;
    res_t q[$];
    logic hold_pend = 1'b0;
    res_t hold_val;

    csa_pipe_addsub #(
        .WIDTH     (WIDTH),
        .GROUP     (GROUP),
        .STAGES    (STAGES)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Reference: plain wide arithmetic, signed range test for overflow.
    function automatic res_t model(input logic [WIDTH-1:0] ma, input logic [WIDTH-1:0] mb,
                                   input logic mcin, input logic msub);
        res_t            r;
        logic [WIDTH-1:0] bb;
        logic [WIDTH:0]   full;
        longint          sg;
        bb     = msub ? ~mb : mb;
        full   = 33'(ma) + 33'(bb) + ((msub || mcin) ? 33'd1 : 33'd0);
        sg     = longint'($signed(ma)) + longint'($signed(bb)) + ((msub || mcin) ? 64'sd1 : 64'sd0);
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (sg > 64'sd2147483647) || (sg < -64'sd2147483648);
        r.zero = (full[WIDTH-1:0] == '0);
        return r;
    endfunction

    function automatic logic [WIDTH-1:0] rand_op();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h7FFF_FFFF;
            3:       return 32'h8000_0000;
            default: return $urandom();
        endcase
    endfunction

    // Compare process: scoreboard on every output handshake, stability while stalled.
    always @(negedge clk) begin
        res_t cur;
        res_t exp_r;
        cur = {zero, ovf, cout, sum};
        if (rst_n !== 1'b1) begin
            q.delete();
            hold_pend = 1'b0;
        end else begin
            if (hold_pend) begin
                check("hold_valid", 64'(out_valid), 64'd1);
                check("hold_data", 64'(cur), 64'(hold_val));
            end
            hold_pend = out_valid & ~out_ready;
            hold_val  = cur;
            if (out_valid && out_ready) begin
                n_out++;
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL out_unexpected: got result %0h, want no output", cur);
                end else begin
                    exp_r = q.pop_front();
                    check("stream", 64'(cur), 64'(exp_r));
                end
            end
            if (in_valid && in_ready) begin
                n_in++;
                q.push_back(model(a, b, cin, sub));
            end
        end
    end

    task automatic directed(input string name, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                            input logic tcin, input logic tsub, input res_t want);
        int lat;
        a         = ta;
        b         = tbv;
        cin       = tcin;
        sub       = tsub;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(STAGES));
        check({name, "_result"}, 64'({zero, ovf, cout, sum}), 64'(want));
        @(posedge clk); #1;
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WIDTH-1:0] got [3];
        int               n;
        int               cyc;
        int               seen;
        logic             acc;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        sub       = 1'b0;

        // Pin the reference model to hand-computed results.
        check("model_skip",   64'(model(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0)), 64'({1'b1, 1'b0, 1'b1, 32'h0000_0000}));
        check("model_sub",    64'(model(32'h5, 32'h7, 1'b1, 1'b1)),         64'({1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE}));
        check("model_ovf_a",  64'(model(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0)), 64'({1'b0, 1'b1, 1'b0, 32'h8000_0000}));
        check("model_ovf_s",  64'(model(32'h8000_0000, 32'h1, 1'b0, 1'b1)), 64'({1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF}));

        // Reset state.
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_sum",       64'(sum),       64'd0);
        check("rst_flags",     64'({cout, ovf, zero}), 64'd0);
        @(posedge clk); #1;

        // Directed corners with literal expectations and latency.
        directed("skip_chain", 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b1, 1'b0, 1'b1, 32'h0000_0000});
        directed("subtract",   32'h5, 32'h7, 1'b1, 1'b1,         {1'b0, 1'b0, 1'b0, 32'hFFFF_FFFE});
        directed("ovf_add",    32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, {1'b0, 1'b1, 1'b0, 32'h8000_0000});
        directed("ovf_sub",    32'h8000_0000, 32'h1, 1'b0, 1'b1, {1'b0, 1'b1, 1'b1, 32'h7FFF_FFFF});

        // Backpressure: two beats fill the pipe, the third waits.
        out_ready = 1'b0;
        cin       = 1'b0;
        sub       = 1'b0;
        a         = 32'd1;
        b         = 32'd1;
        in_valid  = 1'b1;
        @(negedge clk);
        check("bp_ready1", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        a = 32'd2;
        b = 32'd2;
        @(negedge clk);
        check("bp_ready2", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        a = 32'd3;
        b = 32'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("bp_full_ready", 64'(in_ready), 64'd0);
            check("bp_hold_sum",   64'({out_valid, sum}), 64'({1'b1, 32'd2}));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        n   = 0;
        cyc = 0;
        while (n < 3 && cyc < 20) begin
            @(negedge clk);
            if (out_valid) begin
                got[n] = sum;
                n++;
            end
            acc = in_valid & in_ready;
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
            cyc++;
        end
        check("bp_count", 64'(n), 64'd3);
        check("bp_order0", 64'(got[0]), 64'd2);
        check("bp_order1", 64'(got[1]), 64'd4);
        check("bp_order2", 64'(got[2]), 64'd6);
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset with two beats in flight and a third presented on the reset edge.
        out_ready = 1'b0;
        a         = 32'h11;
        b         = 32'h22;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        a = 32'h33;
        b = 32'h44;
        @(posedge clk); #1;
        a         = 32'h55;
        b         = 32'h66;
        out_ready = 1'b1;
        rst_n     = 1'b0;
        @(negedge clk);
        check("midrst_inflight", 64'(out_valid), 64'd1);
        @(posedge clk); #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        check("midrst_sum",       64'(sum),       64'd0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_emit", 64'(seen), 64'd0);
        @(posedge clk); #1;

        // Random streaming with random backpressure.
        n_in  = 0;
        n_out = 0;
        cyc   = 0;
        while (n_in < 10000 && cyc < 60000) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            a         = rand_op();
            b         = ($urandom_range(0, 7) == 0) ? a : rand_op();
            cin       = 1'($urandom_range(0, 1));
            sub       = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            cyc++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        @(negedge clk);
        check("rand_enough_beats", 64'(n_in >= 10000), 64'd1);
        check("rand_drained",      64'(q.size()), 64'd0);
        check("rand_in_eq_out",    64'(n_out), 64'(n_in));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
